decode_queue_ctrl: RTL
======================

// Module: decode_queue_ctrl
// PURPOSE
//  Instruction buffer and sequencer in front of the combinational RV64 decoder.
//  - Accepts fetched {instruction, pc, branch_taken} over valid/ready.
//  - Presents the oldest entry to the decoder and hands it to dispatch/rename.
//  - Watches the decoder's ecall/unsupported flags to drain, halt or trap the front end.
//  - Clears on pipeline flush (mispredict/redirect).
// PARAMETERS
//  DEPTH       4   queue entries; power of two, >= 2
//  INSTR_WIDTH 32  instruction width (`INSTRUCTION_SIZE)
//  PC_WIDTH    64  pc width (`DATA_SIZE)
// PORTS
//  clk                 in   1            clock, all state on rising edge
//  reset               in   1            asynchronous, active-high
//  fetch_valid         in   1            fetch offers an entry
//  fetch_ready         out  1            queue accepts the entry this cycle
//  fetch_instruction   in   INSTR_WIDTH  fetched instruction
//  fetch_pc            in   PC_WIDTH     pc of fetched instruction
//  fetch_branch_taken  in   1            predictor direction for this entry
//  dec_instruction     out  INSTR_WIDTH  head entry, drives decoder instruction
//  dec_branch_taken    out  1            head entry, drives decoder branch_taken
//  dec_pc              out  PC_WIDTH     head entry pc, to dispatch
//  dec_valid           out  1            head entry is offered to dispatch
//  dec_ready           in   1            dispatch/rename accepts head this cycle
//  ctrl_ecall          in   1            decoder ctrl_bits.ecall for head entry
//  ctrl_unsupported    in   1            decoder ctrl_bits.unsupported for head entry
//  rob_empty           in   1            no instructions in flight in the ROB
//  flush               in   1            discard all queued entries
//  count               out  $clog2(DEPTH)+1  current occupancy
//  halted              out  1            ecall retired and pipeline drained
//  trap_unsupported    out  1            head entry is an unsupported opcode
//  trap_pc             out  PC_WIDTH     pc of the unsupported instruction
// BEHAVIOUR
//  Reset: pointers = 0, count = 0, state = RUN.
//   - All stored entries are don't-care; dec_* are driven 0 while the queue is empty.
//   - halted = 0, trap_unsupported = 0, trap_pc = 0.
//  Storage: circular buffer with wr_ptr/rd_ptr of $clog2(DEPTH)+1 bits.
//   - The extra bit is the wrap bit.
//   - empty = pointers equal; full = indices equal and wrap bits differ.
//  Push: fetch_valid & fetch_ready; fetch_ready = ~full & (state==RUN).
//   - Push in cycle N is visible on dec_* in cycle N+1; there is no bypass.
//  Pop: dec_valid & dec_ready.
//   - dec_valid = ~empty & (state==RUN) & ~ctrl_unsupported.
//   - dec_* show the head entry whenever the queue is not empty, so the decoder output is always current.
//  Simultaneous push and pop: allowed when neither full nor empty; count unchanged.
//  Full: no push; a pop in that cycle does not enable a same-cycle push, because full is registered.
//  Pointer wrap: the index wraps modulo DEPTH and the wrap bit toggles.
//  FSM (state enum):
//   RUN   -> DRAIN if ctrl_ecall & pop (the ecall is dispatched).
//         -> TRAP  if ~empty & ctrl_unsupported; the entry is not popped; trap_pc <= dec_pc.
//   DRAIN -> no push, no pop; -> HALT when rob_empty.
//   HALT  -> halted = 1; terminal until reset; flush ignored.
//   TRAP  -> trap_unsupported = 1, trap_pc held; -> RUN on flush.
//  Flush (RUN/DRAIN/TRAP):
//   - Next cycle: rd_ptr = wr_ptr = 0, count = 0, state = RUN, trap_unsupported = 0.
//   - A push or pop in the flush cycle is discarded; flush wins.
//  Flush vs transition: flush in the same cycle as an ecall pop or an unsupported detect takes priority; state stays RUN.
//  Reset mid-operation: immediate, regardless of state or handshake.
// STRUCTURE
//  Shared package:
//   - dq_state_t enum {RUN, DRAIN, HALT, TRAP}.
//   - dq_entry_t packed struct {instruction, pc, branch_taken}.
//  Sub-module decode_fifo: parameterised circular buffer of dq_entry_t with push/pop/full/empty/count/clear.
//  This module holds the FSM, the handshake gating and the trap registers.
// TESTING
//  1. Reset, push 3 entries (pc 0x100, 0x104, 0x108), dec_ready=1 -> dispatched in order, first on cycle after push, count returns 0.
//  2. dec_ready=0, push 5 -> fetch_ready drops after 4, count=4; pop+push same cycle at count=3 -> count stays 3; 6 wraps keep order.
//  3. Head decodes ecall (0x00000073) -> popped, fetch_ready=0, no further dec_valid; rob_empty rises 3 cycles later -> halted=1 next cycle; later flush -> stays halted.
//  4. Head decodes unsupported at pc 0x200 -> dec_valid=0, trap_unsupported=1, trap_pc=0x200; flush -> count=0, state RUN, trap cleared.
//  5. Flush asserted with fetch_valid=1 and dec_ready=1 at count=2 -> no dispatch, no push, count=0 next cycle.
//  6. Reset asserted mid-DRAIN, asynchronously between clock edges -> outputs reset immediately; normal push/pop after release.

Source files
------------

// File: rtl/decode_queue_ctrl_pkg.sv
// rtl/decode_queue_ctrl_pkg.sv - shared state and entry types for the decode queue
package decode_queue_ctrl_pkg;

  localparam int DQ_INSTR_WIDTH = 32;
  localparam int DQ_PC_WIDTH    = 64;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    HALT  = 2'd2,
    TRAP  = 2'd3
  } dq_state_t;

  typedef struct packed {
    logic [DQ_INSTR_WIDTH-1:0] instruction;
    logic [DQ_PC_WIDTH-1:0]    pc;
    logic                      branch_taken;
  } dq_entry_t;

endpackage

// File: rtl/decode_queue_ctrl_fifo.sv
// rtl/decode_queue_ctrl_fifo.sv - circular buffer of dq_entry_t with wrap-bit pointers
module decode_fifo
  import decode_queue_ctrl_pkg::*;
#(
  parameter int  DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        push,
  input  logic        pop,
  input  dq_entry_t   wr_data,
  output dq_entry_t   rd_data,
  output logic        full,
  output logic        empty,
  output logic [AW:0] count
);

  localparam logic [AW:0] PTR_ONE = 1;

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  dq_entry_t   mem_q [DEPTH];
  logic        do_push, do_pop;

  // Top bit is the wrap bit: equal indices mean empty or full depending on it.
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign count   = wr_ptr_q - rd_ptr_q;
  assign rd_data = mem_q[rd_ptr_q[AW-1:0]];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/decode_queue_ctrl.sv
// rtl/decode_queue_ctrl.sv - instruction buffer and front-end sequencer ahead of the decoder
module decode_queue_ctrl
  import decode_queue_ctrl_pkg::*;
#(
  parameter int  DEPTH       = 4,
  parameter int  INSTR_WIDTH = 32,
  parameter int  PC_WIDTH    = 64,
  localparam int CW          = $clog2(DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   fetch_valid,
  output logic                   fetch_ready,
  input  logic [INSTR_WIDTH-1:0] fetch_instruction,
  input  logic [PC_WIDTH-1:0]    fetch_pc,
  input  logic                   fetch_branch_taken,
  output logic [INSTR_WIDTH-1:0] dec_instruction,
  output logic                   dec_branch_taken,
  output logic [PC_WIDTH-1:0]    dec_pc,
  output logic                   dec_valid,
  input  logic                   dec_ready,
  input  logic                   ctrl_ecall,
  input  logic                   ctrl_unsupported,
  input  logic                   rob_empty,
  input  logic                   flush,
  output logic [CW-1:0]          count,
  output logic                   halted,
  output logic                   trap_unsupported,
  output logic [PC_WIDTH-1:0]    trap_pc
);

  dq_state_t           state_q, state_d;
  logic [PC_WIDTH-1:0] trap_pc_q, trap_pc_d;
  dq_entry_t           wr_entry, head;
  logic                full, empty, push, pop, clear, in_run;

  assign in_run      = (state_q == RUN);
  assign fetch_ready = ~full & in_run;
  assign dec_valid   = ~empty & in_run & ~ctrl_unsupported;
  // Flush discards any handshake made in the same cycle.
  assign push        = fetch_valid & fetch_ready & ~flush;
  assign pop         = dec_valid & dec_ready & ~flush;
  assign clear       = flush & (state_q != HALT);

  assign wr_entry.instruction  = fetch_instruction;
  assign wr_entry.pc           = fetch_pc;
  assign wr_entry.branch_taken = fetch_branch_taken;

  decode_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .clear   (clear),
    .push    (push),
    .pop     (pop),
    .wr_data (wr_entry),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  assign dec_instruction  = empty ? '0 : head.instruction;
  assign dec_pc           = empty ? '0 : head.pc;
  assign dec_branch_taken = empty ? 1'b0 : head.branch_taken;

  assign halted           = (state_q == HALT);
  assign trap_unsupported = (state_q == TRAP);
  assign trap_pc          = trap_pc_q;

  always_comb begin
    state_d   = state_q;
    trap_pc_d = trap_pc_q;
    case (state_q)
      RUN: begin
        if (flush) begin
          state_d = RUN;
        end else if (!empty && ctrl_unsupported) begin
          state_d   = TRAP;
          trap_pc_d = dec_pc;
        end else if (ctrl_ecall && pop) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (flush)          state_d = RUN;
        else if (rob_empty) state_d = HALT;
      end
      TRAP:    if (flush) state_d = RUN;
      HALT:    state_d = HALT;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= RUN;
      trap_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      trap_pc_q <= trap_pc_d;
    end
  end

endmodule
